// File: rtl/iter_shift_ctrl_pkg.sv
// Shared definitions for the iterative shifter: ALU op encodings and FSM states.
// The ALU decoder uses the same op constants.
package iter_shift_ctrl_pkg;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/iter_shift_ctrl_shift_step_1.sv
// One-bit shift stage: SLL, SRL or SRA by a single position, selected by op.
// The reserved op passes the operand through unchanged.
module shift_step_1
    import iter_shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] sll_1;
    logic [WIDTH-1:0] srl_1;
    logic [WIDTH-1:0] sra_1;

    assign sll_1 = {in[WIDTH-2:0], 1'b0};
    assign srl_1 = {1'b0, in[WIDTH-1:1]};
    assign sra_1 = {in[WIDTH-1], in[WIDTH-1:1]};

    always_comb begin
        out = in;
        case (op)
            OP_SLL:  out = sll_1;
            OP_SRL:  out = srl_1;
            OP_SRA:  out = sra_1;
            default: out = in;
        endcase
    end

endmodule

// File: rtl/iter_shift_ctrl.sv
// Multi-cycle shifter for the ALU shift path: one bit per clock for shamt cycles,
// with a start/busy/done handshake and a result register held until the next result.
module iter_shift_ctrl
    import iter_shift_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_step;
    logic [SHAMT_W-1:0] count;
    logic [1:0]         op_q;
    logic               accept;
    logic               last_step;

    shift_step_1 #(.WIDTH(WIDTH)) u_step (
        .in  (acc),
        .op  (op_q),
        .out (acc_step)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (count == SHAMT_W'(1)) begin
                    last_step = 1'b1;
                    state_nx  = ST_DONE;
                end
            end
            ST_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // result is written only on entry to DONE so it stays valid while the next op shifts
    always_ff @(posedge clock) begin
        if (reset) begin
            acc    <= '0;
            count  <= '0;
            op_q   <= OP_SLL;
            result <= '0;
        end else if (accept) begin
            acc   <= data_in;
            op_q  <= op;
            count <= shamt;
            if (shamt == '0) begin
                result <= data_in;
            end
        end else if (state == ST_SHIFT) begin
            acc   <= acc_step;
            count <= count - SHAMT_W'(1);
            if (last_step) begin
                result <= acc_step;
            end
        end
    end

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Directed bench for iter_shift_ctrl: a cycle-level reference model checked every
// cycle, plus literal latency/result expectations for each scenario.
module tb_iter_shift_ctrl;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;
    int rc    = 0;

    iter_shift_ctrl #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d,
                                              input logic [4:0] s);
        case (o)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'($signed(d) >>> s);
            default: return d;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted op finishes shamt cycles after the cycle following accept.
    bit          m_busy = 0;
    bit          m_done = 0;
    int          m_left = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_res  = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_left = 0; m_res = '0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1; m_res = m_pend;
            end
        end else if (start) begin
            m_busy = 1;
            m_pend = ref_shift(op, data_in, shamt);
            m_left = int'(shamt);
            if (shamt == 5'd0) begin
                m_done = 1; m_res = m_pend;
            end
        end
        #1;
        check("model_busy",   32'(busy), 32'(m_busy));
        check("model_done",   32'(done), 32'(m_done));
        check("model_result", result,    m_res);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            rc++;
        end
    endtask

    // Starts at a negedge (cycle 0), holds start through the accept edge, then scrambles inputs.
    task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        start = 1'b1; op = o; data_in = d; shamt = s;
        rc = 0;
        tick(1);
        start = 1'b0;
        op = 2'($urandom_range(0, 3));
        data_in = $urandom;
        shamt = 5'($urandom_range(0, 31));
    endtask

    task automatic expect_done(input string name, input int lat, input logic [31:0] r);
        while (!done && rc < lat + 8) tick(1);
        check({name, "_latency"}, 32'(rc), 32'(lat));
        check({name, "_result"}, result, r);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; data_in = '0; shamt = '0;
        repeat (3) @(negedge clock);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'h0);
        reset = 1'b0;
        tick(2);

        issue(2'b10, 32'h8000_0000, 5'd4);
        check("sra_busy_c1", 32'(busy), 32'd1);
        expect_done("sra4", 5, 32'hF800_0000);
        tick(1);
        check("sra_idle_c6", 32'(busy), 32'd0);
        tick(2);

        issue(2'b01, 32'h8000_0000, 5'd4);
        expect_done("srl4", 5, 32'h0800_0000);
        tick(2);

        issue(2'b00, 32'h0000_0001, 5'd31);
        expect_done("sll31", 32, 32'h8000_0000);
        tick(2);

        issue(2'b10, 32'hDEAD_BEEF, 5'd0);
        expect_done("sra0", 1, 32'hDEAD_BEEF);
        tick(2);

        issue(2'b11, 32'hA5A5_5A5A, 5'd7);
        expect_done("rsvd7", 8, 32'hA5A5_5A5A);
        tick(2);

        issue(2'b00, 32'h0000_0001, 5'd8);
        tick(2);
        start = 1'b1; op = 2'b00; data_in = 32'h0000_FFFF; shamt = 5'd1;
        tick(1);
        start = 1'b0;
        expect_done("busy_ignore", 9, 32'h0000_0100);
        tick(1);
        issue(2'b01, 32'h1234_5678, 5'd3);
        expect_done("after_busy", 4, 32'h0246_8ACF);
        tick(2);

        issue(2'b10, 32'hF000_0000, 5'd20);
        tick(5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'h0);
        begin
            int seen = 0;
            while (rc < 25) begin
                tick(1);
                if (done) seen++;
            end
            check("abort_no_done", 32'(seen), 32'd0);
        end
        tick(2);

        issue(2'b01, 32'h0000_00FF, 5'd2);
        expect_done("b2b_first", 3, 32'h0000_003F);
        tick(1);
        issue(2'b10, 32'h8000_0000, 5'd1);
        check("b2b_hold_result", result, 32'h0000_003F);
        check("b2b_second_busy", 32'(busy), 32'd1);
        expect_done("b2b_second", 2, 32'hC000_0000);
        tick(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
